// File: rtl/ps2_device_tx.sv
// Device-side PS/2 transmitter (keyboard model): FIFO-buffered scancodes sent as 11-bit frames.
// Optional build macro PS2_TX_BREAK_EN adds a per-entry break flag that prefixes the code with 0xF0.
`timescale 1ns/1ps
module ps2_device_tx #(
  parameter int CLK_DIV    = 50,
  parameter int FIFO_AW    = 2,
  parameter int GAP_CYCLES = 200
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [7:0]       in_data,
`ifdef PS2_TX_BREAK_EN
  input  logic             in_break,
`endif
  output logic             in_ready,
  output logic             ps2_clk,
  output logic             ps2_data,
  output logic             busy,
  output logic             tx_done,
  output logic [FIFO_AW:0] fifo_level
);

  localparam int DEPTH   = 1 << FIFO_AW;
  localparam int MAX_CNT = (CLK_DIV > GAP_CYCLES) ? CLK_DIV : GAP_CYCLES;
  localparam int HC_W    = $clog2(MAX_CNT) + 1;
`ifdef PS2_TX_BREAK_EN
  localparam int ENT_W   = 9;
`else
  localparam int ENT_W   = 8;
`endif

  localparam logic [HC_W-1:0]  HALF_LAST  = HC_W'(CLK_DIV - 1);
  localparam logic [HC_W-1:0]  GAP_LAST   = HC_W'(GAP_CYCLES - 1);
  localparam logic [HC_W-1:0]  HC_ONE     = HC_W'(1);
  localparam logic [3:0]       LAST_BIT   = 4'd10;
  localparam logic [FIFO_AW:0] FULL_LVL   = (FIFO_AW+1)'(DEPTH);
  localparam logic [FIFO_AW:0] LVL_ONE    = (FIFO_AW+1)'(1);
  localparam logic [FIFO_AW-1:0] PTR_ONE  = FIFO_AW'(1);

  typedef enum logic [1:0] {S_IDLE, S_HIGH, S_LOW, S_GAP} state_t;

  // Frame is sent LSB first: start, data[0..7], odd parity, stop.
  function automatic logic [10:0] make_frame(input logic [7:0] b);
    return {1'b1, ~^b, b, 1'b0};
  endfunction

  state_t             state_q, state_d;
  logic [ENT_W-1:0]   mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
  logic [FIFO_AW:0]   level;
  logic [ENT_W-1:0]   in_entry, head;
  logic               push, pop, fifo_empty;
  logic [HC_W-1:0]    half_cnt;
  logic [3:0]         bit_cnt;
  logic [10:0]        shift;
  logic [10:0]        load_frame;
  logic               half_end, gap_end;
  logic               load, next_bit, frame_end;
  logic               code_pend;

`ifdef PS2_TX_BREAK_EN
  localparam logic [7:0] BREAK_CODE = 8'hF0;
  logic [7:0] code_q;

  assign in_entry = {in_break, in_data};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      code_pend <= 1'b0;
    end else if (pop) begin
      code_pend <= head[8];
    end else if (load) begin
      code_pend <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (pop) code_q <= head[7:0];
  end
`else
  assign in_entry  = in_data;
  assign code_pend = 1'b0;
`endif

  assign fifo_empty = (level == '0);
  assign in_ready   = (level != FULL_LVL);
  assign fifo_level = level;
  assign push       = in_valid & in_ready;
  assign head       = mem[rd_ptr];
  assign half_end   = (half_cnt == HALF_LAST);
  assign gap_end    = (half_cnt == GAP_LAST);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_entry;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({push, pop})
        2'b10:   level <= level + LVL_ONE;
        2'b01:   level <= level - LVL_ONE;
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (!fifo_empty) state_d = S_HIGH;
      S_HIGH:  if (half_end)    state_d = S_LOW;
      S_LOW:   if (half_end)    state_d = (bit_cnt == LAST_BIT) ? S_GAP : S_HIGH;
      S_GAP:   if (gap_end)     state_d = code_pend ? S_HIGH : S_IDLE;
      default:                  state_d = S_IDLE;
    endcase
  end

  // Control strobes decoded from the current state; a pending code frame reloads straight out of GAP.
  always_comb begin
    pop        = 1'b0;
    load       = 1'b0;
    next_bit   = 1'b0;
    frame_end  = 1'b0;
    load_frame = make_frame(head[7:0]);
    unique case (state_q)
      S_IDLE: begin
        pop  = !fifo_empty;
        load = !fifo_empty;
      end
      S_LOW: begin
        if (half_end) begin
          next_bit  = (bit_cnt != LAST_BIT);
          frame_end = (bit_cnt == LAST_BIT);
        end
      end
      S_GAP:   load = gap_end & code_pend;
      default: ;
    endcase
`ifdef PS2_TX_BREAK_EN
    if (state_q == S_GAP)  load_frame = make_frame(code_q);
    else if (head[8])      load_frame = make_frame(BREAK_CODE);
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      half_cnt <= '0;
      bit_cnt  <= '0;
      ps2_clk  <= 1'b1;
      ps2_data <= 1'b1;
      busy     <= 1'b0;
      tx_done  <= 1'b0;
    end else begin
      half_cnt <= (state_d != state_q || state_q == S_IDLE) ? '0 : half_cnt + HC_ONE;
      if (load)          bit_cnt <= '0;
      else if (next_bit) bit_cnt <= bit_cnt + 4'd1;
      ps2_clk <= (state_d != S_LOW);
      // Data only moves on entry to a high phase, so it is stable for the whole low phase.
      if (load)           ps2_data <= load_frame[0];
      else if (next_bit)  ps2_data <= shift[1];
      else if (frame_end) ps2_data <= 1'b1;
      busy    <= (state_d != S_IDLE);
      tx_done <= frame_end;
    end
  end

  always_ff @(posedge clk) begin
    if (load)          shift <= load_frame;
    else if (next_bit) shift <= {1'b1, shift[10:1]};
  end

endmodule

// File: tb/tb_ps2_device_tx.sv
// Directed bench for ps2_device_tx: decodes frames at ps2_clk falls and compares to hand-computed values.
`timescale 1ns/1ps
module tb_ps2_device_tx;
  localparam int CLK_DIV    = 4;
  localparam int FIFO_AW    = 2;
  localparam int GAP_CYCLES = 8;
  localparam int FRAME_CYC  = 22 * CLK_DIV;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic [7:0]       in_data;
`ifdef PS2_TX_BREAK_EN
  logic             in_break;
`endif
  logic             in_ready;
  logic             ps2_clk;
  logic             ps2_data;
  logic             busy;
  logic             tx_done;
  logic [FIFO_AW:0] fifo_level;

  int n_checks = 0;
  int n_errors = 0;

  ps2_device_tx #(
    .CLK_DIV    (CLK_DIV),
    .FIFO_AW    (FIFO_AW),
    .GAP_CYCLES (GAP_CYCLES)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_data    (in_data),
`ifdef PS2_TX_BREAK_EN
    .in_break   (in_break),
`endif
    .in_ready   (in_ready),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .busy       (busy),
    .tx_done    (tx_done),
    .fifo_level (fifo_level)
  );

  always #5 clk = ~clk;

  int          cyc = 0;
  int          done_cnt = 0;
  int          mon_bits = 0;
  logic        prev_clk = 1'b1;
  logic [10:0] mon_sh;
  logic [10:0] frames [$];
  int          fall0 [$];

  always @(posedge clk) cyc <= cyc + 1;

  // Line monitor: captures ps2_data at every ps2_clk fall, bit 0 of a frame first.
  always @(negedge clk) begin
    if (rst) begin
      mon_bits <= 0;
      prev_clk <= 1'b1;
    end else begin
      prev_clk <= ps2_clk;
      if (tx_done) done_cnt <= done_cnt + 1;
      if (prev_clk && !ps2_clk) begin
        if (mon_bits == 0) fall0.push_back(cyc);
        if (mon_bits == 10) begin
          frames.push_back({ps2_data, mon_sh[10:1]});
          mon_bits <= 0;
        end else begin
          mon_sh   <= {ps2_data, mon_sh[10:1]};
          mon_bits <= mon_bits + 1;
        end
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    int n;
    n = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = b;
    while (!in_ready && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) check("send_ready", in_ready, 1);
    @(posedge clk);
  endtask

  task automatic release_in;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_frames(input int n, input string tag);
    int k;
    k = 0;
    while (frames.size() < n && k < 5000) begin
      @(negedge clk);
      k++;
    end
    check(tag, frames.size(), n);
  endtask

  task automatic wait_idle(input string tag);
    int k;
    k = 0;
    while (busy && k < 5000) begin
      @(negedge clk);
      k++;
    end
    check(tag, busy, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  int         base, dbase, fb, k, t0;
  logic [7:0] bp [6];

  initial begin
    bp = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    in_valid = 1'b0;
    in_data  = 8'h00;
`ifdef PS2_TX_BREAK_EN
    in_break = 1'b0;
`endif
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_ps2_clk", ps2_clk, 1);
    check("rst_ps2_data", ps2_data, 1);
    check("rst_busy", busy, 0);
    check("rst_tx_done", tx_done, 0);
    check("rst_level", fifo_level, 0);
    check("rst_in_ready", in_ready, 1);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Single byte 0x1C with latency and busy window.
    base  = frames.size();
    dbase = done_cnt;
    send(8'h1C);
    release_in;
    check("s1_level_after_accept", fifo_level, 1);
    check("s1_busy_before_pop", busy, 0);
    @(negedge clk);
    t0 = cyc;
    check("s1_busy_on_pop", busy, 1);
    check("s1_start_bit", ps2_data, 0);
    check("s1_clk_high", ps2_clk, 1);
    check("s1_level_after_pop", fifo_level, 0);
    k = 1;
    while (ps2_clk && k < 100) begin
      @(negedge clk);
      k++;
    end
    check("s1_first_fall", k, 1 + CLK_DIV);
    wait_idle("s1_idle");
    check("s1_busy_cycles", cyc - t0, FRAME_CYC + GAP_CYCLES);
    check("s1_frames", frames.size(), base + 1);
    if (frames.size() > base) check("s1_frame_1C", frames[base], 11'b10000111000);
    check("s1_tx_done", done_cnt - dbase, 1);

    // Parity corners, back to back, with frame-to-frame period.
    base = frames.size();
    fb   = fall0.size();
    send(8'h00);
    send(8'hFF);
    release_in;
    wait_frames(base + 2, "par_frames");
    wait_idle("par_idle");
    if (frames.size() >= base + 2) begin
      check("par_frame_00", frames[base], 11'b11000000000);
      check("par_frame_FF", frames[base+1], 11'b11111111110);
      check("par_period", fall0[fb+1] - fall0[fb], FRAME_CYC + GAP_CYCLES + 1);
    end

    // Backpressure: first byte pops, next four fill the FIFO.
    base = frames.size();
    for (int i = 0; i < 5; i++) send(bp[i]);
    @(negedge clk);
    check("bp_level_full", fifo_level, 4);
    check("bp_ready_low", in_ready, 0);
    send(bp[5]);
    release_in;
    wait_frames(base + 6, "bp_frames");
    wait_idle("bp_idle");
    repeat (20) @(negedge clk);
    check("bp_no_dup", frames.size(), base + 6);
    if (frames.size() >= base + 6) begin
      for (int i = 0; i < 6; i++) begin
        check($sformatf("bp_byte%0d", i), frames[base+i][8:1], bp[i]);
        check($sformatf("bp_parity%0d", i), ^frames[base+i][9:1], 1);
        check($sformatf("bp_framing%0d", i), {frames[base+i][10], frames[base+i][0]}, 2'b10);
      end
    end

    // Reset in the low phase of data bit 5 of 0x1C, with 0x33 still queued.
    base = frames.size();
    send(8'h1C);
    send(8'h33);
    release_in;
    k = 0;
    while (mon_bits != 7 && k < 2000) begin
      @(negedge clk);
      k++;
    end
    check("rm_bits_seen", mon_bits, 7);
    check("rm_pre_clk", ps2_clk, 0);
    check("rm_pre_data", ps2_data, 0);
    check("rm_pre_level", fifo_level, 1);
    #2 rst = 1'b1;
    #1;
    check("rm_clk_idle", ps2_clk, 1);
    check("rm_data_idle", ps2_data, 1);
    check("rm_level", fifo_level, 0);
    check("rm_busy", busy, 0);
    check("rm_ready", in_ready, 1);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("rm_no_partial", frames.size(), base);
    send(8'h15);
    release_in;
    wait_frames(base + 1, "rm_frames");
    wait_idle("rm_idle");
    repeat (20) @(negedge clk);
    check("rm_single_frame", frames.size(), base + 1);
    if (frames.size() > base) check("rm_frame_15", frames[base], 11'b10000101010);

`ifdef PS2_TX_BREAK_EN
    // Break entry: 0xF0 frame, gap, code frame, gap, busy throughout.
    base  = frames.size();
    dbase = done_cnt;
    in_break = 1'b1;
    send(8'h15);
    release_in;
    in_break = 1'b0;
    check("brk_level", fifo_level, 1);
    @(negedge clk);
    t0 = cyc;
    wait_idle("brk_idle");
    check("brk_busy_cycles", cyc - t0, 2 * (FRAME_CYC + GAP_CYCLES));
    check("brk_frames", frames.size(), base + 2);
    if (frames.size() >= base + 2) begin
      check("brk_frame_F0", frames[base], 11'b11111100000);
      check("brk_frame_15", frames[base+1], 11'b10000101010);
    end
    check("brk_tx_done", done_cnt - dbase, 2);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ps2_device_tx.md
Name: ps2_device_tx

Overview:
- Device-side PS/2 transmitter, i.e. a keyboard model.
- Accepts scancode bytes over a valid/ready interface and buffers them in a small FIFO.
- Serialises each byte as a standard 11-bit PS/2 device-to-host frame, generating both ps2_clk and ps2_data from the system clock.
- Used to drive the PS/2 receiver in simulation and on-board loopback without a physical keyboard.

Parameters:
- CLK_DIV, 50, system clocks per ps2_clk half-period (>=4).
- FIFO_AW, 2, FIFO address width; depth = 2^FIFO_AW = 4.
- GAP_CYCLES, 200, idle cycles (both lines high) enforced after every frame (>=1).

Ports:
- clk  in  1  system clock, all logic on posedge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  byte offered.
- in_data  in  8  scancode byte.
- in_ready  out  1  FIFO not full; a byte is accepted when in_valid & in_ready at a posedge.
- ps2_clk  out  1  generated PS/2 clock, idle high.
- ps2_data  out  1  generated PS/2 data, idle high.
- busy  out  1  high from frame load through end of gap.
- tx_done  out  1  one-cycle pulse on the cycle the stop bit's low phase ends.
- fifo_level  out  FIFO_AW+1  current FIFO occupancy.

Behaviour:
- Reset (async, immediate): ps2_clk=1, ps2_data=1, busy=0, tx_done=0, fifo_level=0, in_ready=1. FIFO pointers cleared and FSM -> IDLE. A frame in progress is abandoned with no partial bits; the lines go idle at once.
- FIFO:
  - Synchronous write on accept; in_ready = (fifo_level != depth).
  - Read and write may occur in the same cycle; the level is then unchanged.
  - Pointers wrap modulo depth.
- Frame shift register (11 bits), sent LSB first: {stop=1, parity, data[7:0], start=0}.
  - parity = ~^data, giving odd parity over data+parity.
- FSM states: IDLE, HIGH, LOW, GAP.
  - IDLE: ps2_clk=1, ps2_data=1. If FIFO non-empty: pop, load shift register, bit_cnt=0, half_cnt=0 -> HIGH; busy=1 from this edge.
  - HIGH: ps2_clk=1, ps2_data=shift[bit_cnt] (registered, set on entry). After CLK_DIV cycles -> LOW.
  - LOW: ps2_clk=0, ps2_data unchanged. After CLK_DIV cycles: if bit_cnt==10, pulse tx_done -> GAP; else bit_cnt+1 -> HIGH.
  - GAP: ps2_clk=1, ps2_data=1 for GAP_CYCLES cycles -> IDLE; busy=0 on the IDLE entry edge.
- Data changes only while ps2_clk is high, at least CLK_DIV cycles before each falling edge. Data is held through the whole low phase.
- Latency: a byte accepted at edge N into an empty FIFO with the FSM in IDLE is popped at edge N+1. The start bit appears at N+1 and the first ps2_clk fall is at N+1+CLK_DIV.
- Frame duration: 22*CLK_DIV cycles; frame-to-frame period: 22*CLK_DIV+GAP_CYCLES+1.
- in_valid while full: no accept, no overwrite. The source must hold in_data until it is accepted.
- Counters: half_cnt is sized ceil(log2(max(CLK_DIV,GAP_CYCLES)))+1 bits; bit_cnt is 4 bits and saturates at 10.

Optional Feature:
- Macro: PS2_TX_BREAK_EN.
- Defined:
  - Adds input in_break (1 bit), sampled with in_data; FIFO entries are 9 bits.
  - A popped entry with break=1 first sends a frame of 0xF0, then GAP, then the code frame, then GAP. busy stays high throughout.
  - tx_done pulses after each of the two frames.
  - fifo_level counts entries, not frames.
- Undefined: port absent, entries 8 bits, one frame per entry.

Test Plan:
- Single byte: reset, CLK_DIV=4, send 0x1C -> ps2_data sampled at the 11 ps2_clk falls is 0,0,0,1,1,1,0,0,0,0,1 (parity 0); tx_done pulses once; busy low after the gap.
- Parity case: send 0x00 -> parity bit 1; send 0xFF -> parity bit 1; stop bit 1 in both frames.
- Backpressure: FIFO_AW=2, hold in_valid with 6 distinct bytes while the FSM is busy -> in_ready low once 4 are queued. All 6 bytes are transmitted in order with no loss or duplication.
- Reset mid-frame: assert rst during bit 5 of 0x1C -> ps2_clk/ps2_data=1 in the same cycle, fifo_level=0. A subsequent send of 0x15 produces a clean frame.
- Loopback: connect to the PS/2 receiver, send 0x12,0x1C,0xF0,0x1C -> the receiver reports each byte in order with no parity or framing errors.
- With PS2_TX_BREAK_EN: send 0x15 with in_break=1 -> frames 0xF0 then 0x15 separated by GAP_CYCLES; tx_done pulses twice.
